// File: rtl/octal_rr_arbiter.sv
// Eight-way round-robin arbiter with registered one-hot grant,
// binary grant index and an optional maximum-hold timeout.
module octal_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam bit               HOLD_ON  = (MAX_HOLD != 0);

  logic [0:0]       state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [2:0]       sel;
  logic [2:0]       idx;
  logic             owner_req;
  logic             force_rel;

  // circular scan from ptr; the lowest offset with a request wins
  always_comb begin
    sel = 3'd0;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (req[idx]) sel = idx;
    end
  end

  // release conditions for the current owner
  always_comb begin
    owner_req = req[gnt_idx];
    force_rel = HOLD_ON && (hold_cnt == HOLD_LIM);
  end

  // arbitration state, hold counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      hold_cnt  <= '0;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req != 8'h00) begin
            state     <= GRANT;
            gnt       <= 8'(1) << sel;
            gnt_idx   <= sel;
            gnt_valid <= 1'b1;
            hold_cnt  <= CNT_W'(1);
          end
        end
        GRANT: begin
          if (!owner_req || force_rel) begin
            state     <= IDLE;
            ptr       <= gnt_idx + 3'd1;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= owner_req;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_octal_rr_arbiter.sv
// Directed bench for octal_rr_arbiter: three instances cover
// MAX_HOLD=16, MAX_HOLD=4 and unlimited hold.
module tb_octal_rr_arbiter;

  logic       clk = 1'b0;
  logic       rsta, rstb, rstc;
  logic [7:0] reqa, reqb, reqc;
  logic [7:0] gnta, gntb, gntc;
  logic [2:0] idxa, idxb, idxc;
  logic       vala, valb, valc;
  logic       toa, tob, toc;
  int         errs   = 0;
  int         checks = 0;
  bit         live   = 1'b0;

  always #5 clk = ~clk;

  octal_rr_arbiter #(.MAX_HOLD(16), .CNT_W(5)) dut_a (
    .clk(clk), .rst(rsta), .req(reqa), .gnt(gnta),
    .gnt_idx(idxa), .gnt_valid(vala), .timeout(toa)
  );

  octal_rr_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rstb), .req(reqb), .gnt(gntb),
    .gnt_idx(idxb), .gnt_valid(valb), .timeout(tob)
  );

  octal_rr_arbiter #(.MAX_HOLD(0), .CNT_W(5)) dut_c (
    .clk(clk), .rst(rstc), .req(reqc), .gnt(gntc),
    .gnt_idx(idxc), .gnt_valid(valc), .timeout(toc)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] enc(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++)
      if (g[i]) r = 3'(i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic inv(input string n, input logic [7:0] g,
                     input logic [2:0] x, input logic v,
                     input logic t);
    check({n, "_onehot0"}, 32'($onehot0(g)), 32'd1);
    check({n, "_valid"}, 32'(v), 32'(|g));
    check({n, "_idx"}, 32'(x), 32'(enc(g)));
    check({n, "_to_excl"}, 32'(t & v), 32'd0);
  endtask

  // per-cycle invariants, sampled mid-cycle
  always @(negedge clk) begin
    if (live) begin
      inv("inv_a", gnta, idxa, vala, toa);
      inv("inv_b", gntb, idxb, valb, tob);
      inv("inv_c", gntc, idxc, valc, toc);
    end
  end

  initial begin
    rsta = 1'b1; rstb = 1'b1; rstc = 1'b1;
    reqa = 8'hFF; reqb = 8'h00; reqc = 8'h00;

    // reset with all requests high
    tick();
    tick();
    live = 1'b1;
    check("rst_gnt", 32'(gnta), 32'h00);
    check("rst_idx", 32'(idxa), 32'd0);
    check("rst_valid", 32'(vala), 32'd0);
    check("rst_to", 32'(toa), 32'd0);
    rsta = 1'b0;
    tick();
    check("first_gnt", 32'(gnta), 32'h01);
    check("first_idx", 32'(idxa), 32'd0);
    check("first_valid", 32'(vala), 32'd1);
    reqa = 8'h00;
    tick();
    check("first_rel", 32'(gnta), 32'h00);
    tick();

    // single requester, other bits ignored while owned
    reqa = 8'h10;
    tick();
    check("single_gnt", 32'(gnta), 32'h10);
    check("single_idx", 32'(idxa), 32'd4);
    check("single_valid", 32'(vala), 32'd1);
    reqa = 8'h11;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("single_hold", 32'(gnta), 32'h10);
    end
    reqa = 8'h00;
    tick();
    check("single_rel", 32'(gnta), 32'h00);
    check("single_rel_to", 32'(toa), 32'd0);
    reqa = 8'h30;
    tick();
    check("ptr5_gnt", 32'(gnta), 32'h20);
    check("ptr5_idx", 32'(idxa), 32'd5);
    reqa = 8'h00;
    tick();
    check("ptr5_rel", 32'(gnta), 32'h00);

    // pointer at 6 wraps past 7 to 0 before reaching 5
    reqa = 8'h21;
    tick();
    check("wrap_gnt", 32'(gnta), 32'h01);
    check("wrap_idx", 32'(idxa), 32'd0);
    reqa = 8'h20;
    tick();
    check("wrap_rel", 32'(gnta), 32'h00);
    check("wrap_dead", 32'(vala), 32'd0);
    tick();
    check("wrap_next", 32'(gnta), 32'h20);
    check("wrap_next_idx", 32'(idxa), 32'd5);
    reqa = 8'h00;
    tick();

    // reset in the middle of a grant
    reqa = 8'h08;
    tick();
    check("mid_gnt", 32'(gnta), 32'h08);
    tick();
    rsta = 1'b1;
    tick();
    check("mid_rst_gnt", 32'(gnta), 32'h00);
    check("mid_rst_idx", 32'(idxa), 32'd0);
    check("mid_rst_valid", 32'(vala), 32'd0);
    check("mid_rst_to", 32'(toa), 32'd0);
    rsta = 1'b0;
    reqa = 8'h0C;
    tick();
    check("post_rst_gnt", 32'(gnta), 32'h04);
    check("post_rst_idx", 32'(idxa), 32'd2);
    reqa = 8'h00;
    tick();

    // rotation with timeout, MAX_HOLD=4
    rstb = 1'b0;
    tick();
    check("rot_idle", 32'(valb), 32'd0);
    reqb = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      check("rot_gnt", 32'(gntb), 32'(8'(1) << (k % 8)));
      check("rot_idx", 32'(idxb), 32'(k % 8));
      check("rot_to_lo", 32'(tob), 32'd0);
      for (int j = 0; j < 3; j++) begin
        tick();
        check("rot_hold", 32'(gntb), 32'(8'(1) << (k % 8)));
      end
      tick();
      check("rot_dead", 32'(gntb), 32'h00);
      check("rot_to", 32'(tob), 32'd1);
    end
    reqb = 8'h00;
    tick();
    check("rot_to_pulse", 32'(tob), 32'd0);

    // unlimited hold, MAX_HOLD=0
    rstc = 1'b0;
    reqc = 8'h08;
    tick();
    check("inf_gnt", 32'(gntc), 32'h08);
    check("inf_idx", 32'(idxc), 32'd3);
    for (int i = 0; i < 99; i++) begin
      tick();
      check("inf_hold", 32'(gntc), 32'h08);
      check("inf_to", 32'(toc), 32'd0);
    end
    reqc = 8'h00;
    tick();
    check("inf_rel", 32'(gntc), 32'h00);
    check("inf_rel_to", 32'(toc), 32'd0);
    tick();

    live = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
